// File: rtl/phase_pkg.sv
// Shared phase-domain definitions for the atan2 / unwrap / demod chain.
// Phase LSB is 2^-(WIDTH-PHASE_FRAC_OFS) rad.
package phase_pkg;

  localparam int PHASE_FRAC_OFS = 3;
  // round(pi * 2^30), rescaled per WIDTH below
  localparam longint unsigned PI_Q30 = 64'd3373259426;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_RUNNING = 2'd2
  } phase_state_e;

  function automatic int pi_cnt(input int width);
    int sh;
    sh = 30 - (width - PHASE_FRAC_OFS);
    return int'((PI_Q30 + (64'd1 << (sh - 1))) >> sh);
  endfunction

  function automatic int two_pi_cnt(input int width);
    return 2 * pi_cnt(width);
  endfunction

endpackage

// File: rtl/phase_unwrap_freq_boxcar.sv
// Boxcar averager over the last 2^AVG_LOG2 deltas; slots not yet written count as 0.
module boxcar_avg #(
  parameter int WIDTH    = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout,
  output logic                    full
);
  localparam int N  = 1 << AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW = WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2:0] N_CNT = (AVG_LOG2 + 1)'(N);

  logic signed [WIDTH-1:0] r_mem [N];
  logic [PW-1:0]           r_ptr;
  logic [AVG_LOG2:0]       r_fill;
  logic signed [SW-1:0]    r_sum;
  logic signed [WIDTH-1:0] w_oldest;

  assign full     = (r_fill == N_CNT);
  assign w_oldest = full ? r_mem[r_ptr] : '0;
  // top WIDTH bits of the sum are exactly sum >>> AVG_LOG2
  assign dout     = r_sum[AVG_LOG2 +: WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr  <= '0;
      r_fill <= '0;
      r_sum  <= '0;
    end else if (push) begin
      r_sum <= r_sum + SW'(din) - SW'(w_oldest);
      r_ptr <= (r_ptr == PW'(N - 1)) ? '0 : r_ptr + 1'b1;
      if (!full) r_fill <= r_fill + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_ptr] <= din;
  end

endmodule

// File: rtl/phase_unwrap_freq.sv
// Phase unwrapper + boxcar-smoothed instantaneous frequency.
// Define PHASE_UNWRAP_SAT_EN to saturate the accumulator (sticky sat_flag) instead of wrapping.
module phase_unwrap_freq
  import phase_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32,
  parameter int AVG_LOG2  = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sink_valid,
  input  logic signed [WIDTH-1:0]     sink,
  output logic                        source_valid,
  output logic signed [ACC_WIDTH-1:0] source_phase,
  output logic                        source_freq_valid,
  output logic signed [WIDTH-1:0]     source_freq
);
  localparam int DW = WIDTH + 2;
  localparam logic signed [DW-1:0] PI_D     = DW'(pi_cnt(WIDTH));
  localparam logic signed [DW-1:0] TWO_PI_D = DW'(two_pi_cnt(WIDTH));

  phase_state_e                r_state;
  logic signed [WIDTH-1:0]     r_prev;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_valid;

  logic signed [DW-1:0]        w_diff, w_dwrap;
  logic signed [WIDTH-1:0]     w_delta;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic                        w_push, w_full;
  logic                        w_unused_dhi;

  // shortest-path delta; exactly +/-pi is left as is
  always_comb begin
    w_diff  = DW'(sink) - DW'(r_prev);
    w_dwrap = w_diff;
    if (w_diff > PI_D)       w_dwrap = w_diff - TWO_PI_D;
    else if (w_diff < -PI_D) w_dwrap = w_diff + TWO_PI_D;
  end
  assign w_delta      = w_dwrap[WIDTH-1:0];
  assign w_unused_dhi = ^w_dwrap[DW-1:WIDTH];
  assign w_push       = sink_valid && (r_state != ST_EMPTY);

`ifdef PHASE_UNWRAP_SAT_EN
  localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH:0] w_acc_wide;
  logic                      w_clip;
  logic                      sat_flag;

  always_comb begin
    w_acc_wide = (ACC_WIDTH + 1)'(r_acc) + (ACC_WIDTH + 1)'(w_delta);
    w_acc_next = w_acc_wide[ACC_WIDTH-1:0];
    w_clip     = 1'b0;
    if (w_acc_wide > ACC_MAX) begin
      w_acc_next = ACC_MAX[ACC_WIDTH-1:0];
      w_clip     = 1'b1;
    end else if (w_acc_wide < ACC_MIN) begin
      w_acc_next = ACC_MIN[ACC_WIDTH-1:0];
      w_clip     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              sat_flag <= 1'b0;
    else if (w_push && w_clip) sat_flag <= 1'b1;
  end
`else
  assign w_acc_next = r_acc + ACC_WIDTH'(w_delta);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_prev  <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= sink_valid;
      if (sink_valid) r_prev <= sink;
      case (r_state)
        ST_EMPTY: if (sink_valid) begin
          r_acc   <= ACC_WIDTH'(sink);
          r_state <= ST_FILLING;
        end
        ST_FILLING: begin
          if (sink_valid) r_acc <= w_acc_next;
          if (w_full)     r_state <= ST_RUNNING;
        end
        default: if (sink_valid) r_acc <= w_acc_next;
      endcase
    end
  end

  boxcar_avg #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) u_boxcar (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .din     (w_delta),
    .dout    (source_freq),
    .full    (w_full)
  );

  assign source_valid      = r_valid;
  assign source_phase      = r_acc;
  assign source_freq_valid = r_valid & w_full;

endmodule

// File: tb/tb_phase_unwrap_freq.sv
// Directed bench for phase_unwrap_freq with a queue-based reference model.
module tb_phase_unwrap_freq;
  localparam int W = 16, AW = 32, L = 3, N = 1 << L;
  localparam int PI = 25736, TPI = 51472;

  logic clk = 1'b0, reset_n = 1'b0, sink_valid = 1'b0;
  logic signed [W-1:0]  sink = '0;
  logic                 source_valid, source_freq_valid;
  logic signed [AW-1:0] source_phase;
  logic signed [W-1:0]  source_freq;

  logic                 s20_valid = 1'b0;
  logic signed [W-1:0]  s20_sink = '0;
  logic                 o20_valid, o20_fv;
  logic signed [19:0]   o20_phase;
  logic signed [W-1:0]  o20_freq;

  int total = 0, bad = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  phase_unwrap_freq #(.WIDTH(W), .ACC_WIDTH(AW), .AVG_LOG2(L)) u_dut (
    .clk(clk), .reset_n(reset_n), .sink_valid(sink_valid), .sink(sink),
    .source_valid(source_valid), .source_phase(source_phase),
    .source_freq_valid(source_freq_valid), .source_freq(source_freq)
  );

  phase_unwrap_freq #(.WIDTH(W), .ACC_WIDTH(20), .AVG_LOG2(L)) u_dut20 (
    .clk(clk), .reset_n(reset_n), .sink_valid(s20_valid), .sink(s20_sink),
    .source_valid(o20_valid), .source_phase(o20_phase),
    .source_freq_valid(o20_fv), .source_freq(o20_freq)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wrap_delta(input int a, input int b);
    int d = a - b;
    if (d > PI) d -= TPI;
    else if (d < -PI) d += TPI;
    return d;
  endfunction

  function automatic int floor_div(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  // Reference model: last-N delta window as a queue, phase as a plain integer sum.
  int dq[$];
  bit m_have;
  int m_prev, m_acc, m_s, m_sum;
  bit e_valid, e_fv;
  int e_phase, e_freq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dq.delete();
      m_have = 0; m_prev = 0; m_acc = 0;
      e_valid = 0; e_fv = 0; e_phase = 0; e_freq = 0;
    end else begin
      e_valid = sink_valid;
      e_fv    = 0;
      if (sink_valid) begin
        m_s = sink;
        if (!m_have) begin
          m_have = 1;
          m_acc  = m_s;
        end else begin
          dq.push_back(wrap_delta(m_s, m_prev));
          m_acc += dq[$];
          if (dq.size() > N) void'(dq.pop_front());
        end
        m_prev  = m_s;
        m_sum   = 0;
        foreach (dq[i]) m_sum += dq[i];
        e_phase = m_acc;
        e_freq  = floor_div(m_sum, N);
        e_fv    = (dq.size() == N);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      chk("cyc_valid", source_valid, e_valid);
      chk("cyc_phase", source_phase, e_phase);
      chk("cyc_fvalid", source_freq_valid, e_fv);
      chk("cyc_freq", source_freq, e_freq);
    end
  end

  task automatic send(input int v);
    sink_valid = 1'b1;
    sink = W'(v);
    @(negedge clk);
    sink_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input bit check);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    if (check) begin
      chk("arst_valid", source_valid, 0);
      chk("arst_phase", source_phase, 0);
      chk("arst_fvalid", source_freq_valid, 0);
      chk("arst_freq", source_freq, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int vec[16] = '{32767, -32768, 0, -25737, 25735, 12000, -31000, 30000,
                  -5, 7, 20000, -20000, -25736, 25736, 100, -3};

  initial begin
    int v;
    repeat (3) @(negedge clk);
    chk("rst_valid", source_valid, 0);
    chk("rst_phase", source_phase, 0);
    chk("rst_fvalid", source_freq_valid, 0);
    chk("rst_freq", source_freq, 0);
    reset_n = 1'b1;
    cmp_en  = 1;

    // linear ramp
    for (int k = 0; k < 12; k++) begin
      send(100 * k);
      if (k == 0) chk("ramp_first_phase", source_phase, 0);
      if (k == 7) chk("ramp_fv_before", source_freq_valid, 0);
      if (k == 8) begin
        chk("ramp_fv_rise", source_freq_valid, 1);
        chk("ramp_freq", source_freq, 100);
      end
    end
    chk("ramp_phase_end", source_phase, 1100);
    idle(3);
    chk("hold_phase", source_phase, 1100);
    chk("hold_valid", source_valid, 0);

    // mid-stream reset
    pulse_reset(0);
    for (int k = 0; k < 5; k++) send(100 * k);
    pulse_reset(1);
    send(500);
    chk("post_rst_phase", source_phase, 500);
    chk("post_rst_fv", source_freq_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      send(500 + 100 * k);
      if (k == 7) chk("post_rst_fv7", source_freq_valid, 0);
      if (k == 8) chk("post_rst_fv8", source_freq_valid, 1);
    end

    // wrap cases and the +/-pi boundary
    pulse_reset(0);
    send(25700); send(-25700);
    chk("pos_wrap_phase", source_phase, 25772);
    pulse_reset(0);
    send(-25700); send(25700);
    chk("neg_wrap_phase", source_phase, -25772);
    pulse_reset(0);
    send(0); send(25736);
    chk("bound_pi_phase", source_phase, 25736);
    send(-25736);
    chk("bound_negpi_phase", source_phase, 25736);

    // mixed vectors with gaps
    pulse_reset(0);
    for (int i = 0; i < 16; i++) begin
      send(vec[i]);
      if (i % 5 == 4) idle(2);
    end
    idle(2);

    // 20-bit accumulator: steady +25000 step
    pulse_reset(0);
    for (int k = 0; k <= 21; k++) begin
      v = (k * 25000) % TPI;
      if (v > PI) v -= TPI;
      s20_valid = 1'b1;
      s20_sink  = W'(v);
      @(negedge clk);
      s20_valid = 1'b0;
      if (k == 20) chk("acc20_k20", o20_phase, 500000);
    end
    chk("acc20_valid", o20_valid, 1);
`ifdef PHASE_UNWRAP_SAT_EN
    chk("acc20_sat", o20_phase, 524287);
    chk("acc20_flag", u_dut20.sat_flag, 1);
`else
    chk("acc20_wrap", o20_phase, -523576);
`endif
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_unwrap_freq.md
Name: phase_unwrap_freq

Overview:
- Downstream stage of the atan2 phase detector.
- Consumes wrapped signed phase words, in units of 2^-(WIDTH-3) rad (8192 counts/rad at WIDTH=16).
- Produces an unwrapped phase accumulator and an instantaneous-frequency estimate. Frequency is the per-sample phase delta, smoothed by a 2^AVG_LOG2-tap boxcar.
- Feeds the demodulator / carrier-tracking logic.

Parameters:
- WIDTH, 16: input phase width, signed two's complement.
- ACC_WIDTH, 32: unwrapped-phase accumulator width, signed; must be > WIDTH.
- AVG_LOG2, 3: log2 of the boxcar length N; legal range 0..6 (N=1..64).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- sink_valid  in  1  sink phase word valid this cycle.
- sink  in  WIDTH  wrapped phase, signed.
- source_valid  out  1  one-cycle pulse per accepted sample.
- source_phase  out  ACC_WIDTH  unwrapped phase, signed.
- source_freq_valid  out  1  high with source_valid once the averaging window is full.
- source_freq  out  WIDTH  averaged phase delta, counts/sample, signed.

Behaviour:
- Constants: PI_CNT = round(pi*2^(WIDTH-3)), which is 25736 at WIDTH=16; TWO_PI_CNT = 2*PI_CNT = 51472.
- No backpressure. A sample is accepted on any rising edge with sink_valid=1.
- Reset (asynchronous, reset_n=0):
  - All outputs are 0.
  - Boxcar RAM contents are don't-care; it is masked by the fill counter.
  - State is EMPTY.
  - Asserting reset mid-stream aborts immediately; the first sample after release is treated as a first sample.
- State machine:
  - EMPTY: no previous sample.
    - On accept: prev<=sink; acc<=sign-extended sink; delta=0, not pushed into the boxcar.
    - source_valid pulses at t+1; source_freq_valid=0.
    - Go to FILLING.
  - FILLING: on each accept, compute delta, push it into the boxcar, fill_cnt++. When fill_cnt reaches N, go to RUNNING; source_freq_valid goes high together with the source_valid of that N-th delta.
  - RUNNING: every accepted sample produces source_valid=source_freq_valid=1 at t+1. No exit except reset.
- Delta arithmetic (WIDTH+1 bits):
  - d = sink - prev.
  - If d > PI_CNT: d -= TWO_PI_CNT. If d < -PI_CNT: d += TWO_PI_CNT.
  - d == ±PI_CNT is left unchanged.
  - The result always fits WIDTH bits signed.
- Accumulator: acc <= acc + sign_ext(d). Default is modulo 2^ACC_WIDTH wrap.
- Boxcar:
  - Circular buffer of N deltas plus a running sum of WIDTH+AVG_LOG2 bits: sum <= sum + d_new - d_oldest.
  - During FILLING the oldest entry is treated as 0.
  - source_freq = sum >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
  - AVG_LOG2=0 passes d straight through, and source_freq_valid rises on the second sample.
- Latency: source_phase and source_freq are registered; both are valid exactly 1 cycle after acceptance.
- Outputs hold their last values while source_valid=0.
- Back-to-back sink_valid every cycle is supported at full rate.

Optional Feature:
- Macro: PHASE_UNWRAP_SAT_EN.
- Defined: the accumulator saturates at +(2^(ACC_WIDTH-1)-1) / -(2^(ACC_WIDTH-1)) instead of wrapping. A sticky internal flag sets on the first clip and is cleared only by reset. The flag is observable hierarchically as sat_flag.
- Undefined: modulo wrap; no flag logic is synthesised.

Decomposition:
- Shared package phase_pkg:
  - function pi_cnt(width) returning PI_CNT / TWO_PI_CNT.
  - Typedef of the state enum {EMPTY, FILLING, RUNNING}.
  - The phase scaling constant, shared with the atan2 stage and its benches.
- Sub-module boxcar_avg:
  - Parameters WIDTH, AVG_LOG2.
  - Ports: clk, reset_n, push, din, dout, full.
  - Owns the circular buffer, running sum and fill counter.
- The top holds the unwrap datapath and the FSM.

Test Plan:
- Linear ramp, AVG_LOG2=3: sink=0,100,200,... one sample per cycle -> source_phase follows 0,100,200,...; source_freq_valid rises with the 9th sample's output (1 cycle after accept); source_freq=100 thereafter.
- Positive wrap: prev=25700, sink=-25700 -> d=+72; source_phase=25772.
- Negative wrap: prev=-25700, sink=25700 -> d=-72; source_phase=-25772.
- Boundary: prev=0, sink=25736 -> d=+25736 (no correction). Then sink=-25736 -> d=-51472+51472=0; source_phase stays 25736.
- Reset mid-stream: after 5 ramp samples, pulse reset_n low for 1 cycle -> all outputs 0 asynchronously. Next sample 500 gives source_phase=500 and source_freq_valid=0 until 8 further deltas.
- With PHASE_UNWRAP_SAT_EN, ACC_WIDTH=20: constant step +25000 -> source_phase clips at 524287, sat_flag=1; without the macro the accumulator wraps negative.
